// File: rtl/wrp_shff_rd_ctrl.sv
// Shuffle-buffer read controller: credit-driven frame reads from a ping-pong URAM, realigned into an AXI4-Stream master.
// Define WRP_SHFF_TRANSPOSE_EN for row/column-swapped addressing; otherwise addressing is linear.
module wrp_shff_rd_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 128,
    parameter int READ_LATENCY = 5,
    parameter int ROW_BITS     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_rdy,
    output logic                  frame_done,
    output logic                  ovf_err,
    output logic [ADDR_WIDTH-1:0] ra,
    input  logic [DATA_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);
    localparam int IW = ADDR_WIDTH - 1;
    localparam logic [IW-1:0] IDX_LAST = '1;
`ifdef WRP_SHFF_TRANSPOSE_EN
    localparam bit TRANSPOSE = 1'b1;
`else
    localparam bit TRANSPOSE = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_READ} state_t;
    state_t state, state_nx;

    logic [1:0]            credits;
    logic                  bank;
    logic [IW-1:0]         idx, idx_cur;
    logic [4:0]            occ;
    logic                  start, active, issue, last_issue;
    logic [ADDR_WIDTH-1:0] addr;

    logic [READ_LATENCY-1:0] pv, pl;
    logic                    land, land_last;

    logic [DATA_WIDTH-1:0] fmem [0:15];
    logic [15:0]           flast;
    logic [3:0]            wptr, rptr;
    logic [4:0]            fcnt;
    logic                  pop, out_free, fifo_rd, fifo_wr;

    // occ covers reads in flight plus every word buffered (FIFO and output register),
    // so gating issue on occ < 16 guarantees a landing slot for each read.
    always_comb begin
        start      = (state == S_IDLE) && (credits != '0);
        active     = start || (state == S_READ);
        idx_cur    = start ? '0 : idx;
        issue      = active && (occ < 5'd16);
        last_issue = issue && (idx_cur == IDX_LAST);
        state_nx   = state;
        if (last_issue)
            state_nx = S_IDLE;
        else if (start)
            state_nx = S_READ;
        if (TRANSPOSE)
            addr = {bank, idx_cur[ROW_BITS-1:0], idx_cur[IW-1:ROW_BITS]};
        else
            addr = {bank, idx_cur};
    end

    always_comb begin
        land      = pv[READ_LATENCY-1];
        land_last = pl[READ_LATENCY-1];
        pop       = m_axis_tvalid && m_axis_tready;
        out_free  = !m_axis_tvalid || m_axis_tready;
        fifo_rd   = out_free && (fcnt != '0);
        fifo_wr   = land && !(out_free && (fcnt == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            credits    <= '0;
            ovf_err    <= 1'b0;
            bank       <= 1'b0;
            idx        <= '0;
            ra         <= '0;
            frame_done <= 1'b0;
            occ        <= '0;
            pv         <= '0;
            pl         <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= last_issue;
            if (issue) begin
                ra  <= addr;
                idx <= idx_cur + IW'(1);
            end else if (start) begin
                idx <= '0;
            end
            if (last_issue)
                bank <= ~bank;
            if (frame_rdy && !start) begin
                if (credits == 2'd2)
                    ovf_err <= 1'b1;
                else
                    credits <= credits + 2'd1;
            end else if (!frame_rdy && start) begin
                credits <= credits - 2'd1;
            end
            occ   <= occ + {4'd0, issue} - {4'd0, pop};
            pv[0] <= issue;
            pl[0] <= last_issue;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
            end
        end
    end

    // Output register refills from the FIFO head first; a landing word bypasses only when the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            wptr          <= '0;
            rptr          <= '0;
            fcnt          <= '0;
        end else begin
            if (out_free) begin
                if (fcnt != '0) begin
                    m_axis_tdata  <= fmem[rptr];
                    m_axis_tlast  <= flast[rptr];
                    m_axis_tvalid <= 1'b1;
                end else if (land) begin
                    m_axis_tdata  <= rd;
                    m_axis_tlast  <= land_last;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
            if (fifo_wr)
                wptr <= wptr + 4'd1;
            if (fifo_rd)
                rptr <= rptr + 4'd1;
            fcnt <= fcnt + {4'd0, fifo_wr} - {4'd0, fifo_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fmem[wptr]  <= rd;
            flast[wptr] <= land_last;
        end
    end
endmodule

// File: tb/tb_wrp_shff_rd_ctrl.sv
// Directed bench for wrp_shff_rd_ctrl: small frame (AW=5, ROW_BITS=2) with a behavioural fixed-latency memory.
module tb_wrp_shff_rd_ctrl;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int RL = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_rdy;
    logic          frame_done;
    logic          ovf_err;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    wrp_shff_rd_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .READ_LATENCY(RL),
        .ROW_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_rdy(frame_rdy),
        .frame_done(frame_done),
        .ovf_err(ovf_err),
        .ra(ra),
        .rd(rd),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mword(input logic [4:0] a);
        return {8'hA5, 3'b000, a};
    endfunction

    function automatic logic [4:0] exp_ra(input logic b, input int unsigned i);
        logic [3:0] x;
        x = i[3:0];
`ifdef WRP_SHFF_TRANSPOSE_EN
        return {b, x[1:0], x[3:2]};
`else
        return {b, x};
`endif
    endfunction

    // Memory model: ra is registered in the issue cycle, so RL-1 further stages give RL cycles from issue.
    logic [15:0] mp [0:RL-2];
    always @(posedge clk) begin
        mp[0] <= mword(ra);
        for (int i = 1; i < RL - 1; i++)
            mp[i] <= mp[i-1];
    end
    assign rd = mp[RL-2];

    int n_run = 0;
    int n_fail = 0;
    int t, tv_first, fd_cnt, fd_cyc;
    logic [4:0] ra_log [0:255];
    logic [16:0] rx_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_logs();
        t = 0;
        tv_first = -1;
        fd_cnt = 0;
        fd_cyc = -1;
        rx_q.delete();
    endtask

    // Called at a falling edge: drive this cycle's inputs, sample this cycle's outputs, advance one cycle.
    task automatic tick(input logic fr, input logic tr, input logic rs);
        frame_rdy = fr;
        m_axis_tready = tr;
        rst = rs;
        if (!rs) begin
            if (t < 256) ra_log[t] = ra;
            if (m_axis_tvalid && tv_first < 0) tv_first = t;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = t;
            end
            if (m_axis_tvalid && tr) rx_q.push_back({m_axis_tlast, m_axis_tdata});
        end
        @(negedge clk);
        t++;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        clear_logs();
    endtask

    task automatic chk_rx(input string tag, input int unsigned nfr, input logic b0);
        logic b;
        logic [16:0] e;
        chk({tag, "_count"}, rx_q.size(), nfr * 16);
        for (int unsigned k = 0; k < nfr * 16 && k < rx_q.size(); k++) begin
            b = b0 ^ (((k / 16) % 2) == 1);
            e = {((k % 16) == 15), mword(exp_ra(b, k % 16))};
            chk($sformatf("%s_w%0d", tag, k), rx_q[k], e);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_rdy = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_ra", ra, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", ovf_err, 0);

        // Single frame, tready high
        tick(1'b1, 1'b1, 1'b0);
        repeat (30) tick(1'b0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 16; i++)
            chk($sformatf("A_ra%0d", i), ra_log[2+i], exp_ra(1'b0, i));
        chk("A_ra_hold", ra_log[30], exp_ra(1'b0, 15));
        chk("A_tvalid_first", tv_first, 7);
        chk("A_done_cnt", fd_cnt, 1);
        chk("A_done_cyc", fd_cyc, 17);
        chk_rx("A", 1, 1'b0);

        // Two credits back to back: banks 0 then 1
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (44) tick(1'b0, 1'b1, 1'b0);
        chk("B_ra17", ra_log[17], exp_ra(1'b0, 15));
        chk("B_ra18", ra_log[18], exp_ra(1'b1, 0));
        chk("B_ra33", ra_log[33], exp_ra(1'b1, 15));
        chk("B_done_cnt", fd_cnt, 2);
        chk("B_ovf", ovf_err, 0);
        chk_rx("B", 2, 1'b0);

        // Backpressure from the first word
        do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        repeat (24) tick(1'b0, 1'b0, 1'b0);
        chk("C_ra17", ra_log[17], exp_ra(1'b0, 15));
        chk("C_ra25", ra_log[25], exp_ra(1'b0, 15));
        chk("C_done_cnt", fd_cnt, 1);
        chk("C_hold_tvalid", m_axis_tvalid, 1);
        chk("C_hold_tdata", m_axis_tdata, mword(exp_ra(1'b0, 0)));
        chk("C_hold_tlast", m_axis_tlast, 0);
        tick(1'b0, 1'b1, 1'b0);
        repeat (9) tick(1'b0, 1'b0, 1'b0);
        chk("C_ra27", ra_log[27], exp_ra(1'b0, 15));
        chk("C_ra28", ra_log[28], exp_ra(1'b1, 0));
        chk("C_ra35", ra_log[35], exp_ra(1'b1, 0));
        chk("C_rx_one", rx_q.size(), 1);
        repeat (55) tick(1'b0, 1'b1, 1'b0);
        chk_rx("C", 2, 1'b0);
        chk("C_done_cnt2", fd_cnt, 2);

        // Overflow while stalled in READ
        do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        repeat (18) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("D_ovf_at2", ovf_err, 0);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        chk("D_ovf_set", ovf_err, 1);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        chk("D_ovf_sticky", ovf_err, 1);
        do_reset();
        chk("D_ovf_cleared", ovf_err, 0);

        // Reset after five issues
        tick(1'b1, 1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        chk("E_tvalid", m_axis_tvalid, 0);
        chk("E_ra", ra, 0);
        chk("E_done", frame_done, 0);
        clear_logs();
        repeat (25) tick(1'b0, 1'b1, 1'b0);
        chk("E_no_stale", rx_q.size(), 0);
        chk("E_no_tvalid", tv_first, 32'hFFFF_FFFF);
        chk("E_ra_idle", ra_log[24], 0);
        chk("E_no_done", fd_cnt, 0);
        clear_logs();
        tick(1'b1, 1'b1, 1'b0);
        repeat (30) tick(1'b0, 1'b1, 1'b0);
        chk("E_ra2", ra_log[2], exp_ra(1'b0, 0));
        chk("E_ra3", ra_log[3], exp_ra(1'b0, 1));
        chk("E_done_cnt", fd_cnt, 1);
        chk_rx("E", 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
